// File: rtl/seven_seg_capture_if.sv
// Display-pin bus for seven_seg_capture: muxed segment/digit pins in, recovered frame out.
// master = display / pin driver side, slave = capture block.
interface seven_seg_capture_if #(
    parameter int unsigned DIGITS = 4
);
    logic [7:0]          seg_n;
    logic [DIGITS-1:0]   dig_n;
    logic [4*DIGITS-1:0] value;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   err;
    logic                frame_valid;
    logic                frame_err;

    modport master (
        output seg_n, dig_n,
        input  value, dp, err, frame_valid, frame_err
    );

    modport slave (
        input  seg_n, dig_n,
        output value, dp, err, frame_valid, frame_err
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Recovers hex digits from a multiplexed common-anode 7-segment bus: synchronise, wait for a
// stable window, decode the glyph into its digit slot, publish whole frames with a strobe.
module seven_seg_capture #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               resetn,
    seven_seg_capture_if.slave bus
);
    localparam int unsigned PW = 8 + DIGITS;

    typedef enum logic {ST_WAIT, ST_HOLD} state_t;

    logic [PW-1:0]       r_sync1, r_s, r_p;
    logic [7:0]          r_cnt;
    state_t              r_state;
    logic [4*DIGITS-1:0] r_stg_val;
    logic [DIGITS-1:0]   r_stg_dp, r_stg_err, r_seen;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_dp, r_err;
    logic                r_fv, r_fe;

    logic [7:0]          w_seg;
    logic [DIGITS-1:0]   w_dig_act, w_cap_mask;
    logic [6:0]          w_pat;
    logic [3:0]          w_nib;
    logic                w_bad, w_dp_lit, w_stable, w_onehot, w_window, w_full;

    assign w_seg     = r_s[PW-1:DIGITS];
    assign w_dig_act = ~r_s[DIGITS-1:0];
    assign w_pat     = ~w_seg[6:0];
    assign w_dp_lit  = ~w_seg[7];
    assign w_stable  = (r_s == r_p);
    assign w_onehot  = (w_dig_act != '0) &&
                       ((w_dig_act & (w_dig_act - DIGITS'(1))) == '0);
    // End of a stability window while waiting; the slot is captured only if exactly one digit is on.
    assign w_window  = (r_state == ST_WAIT) && (r_cnt == 8'(STABLE_CYCLES - 1)) &&
                       (w_stable || (STABLE_CYCLES == 1));
    assign w_cap_mask = (w_window && w_onehot) ? w_dig_act : '0;
    assign w_full     = &r_seen;

    // Glyph to nibble; unknown patterns flag an error and read as zero.
    always_comb begin
        w_nib = 4'h0;
        w_bad = 1'b0;
        case (w_pat)
            7'h3F: w_nib = 4'h0;
            7'h06: w_nib = 4'h1;
            7'h5B: w_nib = 4'h2;
            7'h4F: w_nib = 4'h3;
            7'h66: w_nib = 4'h4;
            7'h6D: w_nib = 4'h5;
            7'h7D: w_nib = 4'h6;
            7'h07: w_nib = 4'h7;
            7'h7F: w_nib = 4'h8;
            7'h67: w_nib = 4'h9;
            7'h77: w_nib = 4'hA;
            7'h7C: w_nib = 4'hB;
            7'h39: w_nib = 4'hC;
            7'h5E: w_nib = 4'hD;
            7'h79: w_nib = 4'hE;
            7'h71: w_nib = 4'hF;
            default: w_bad = 1'b1;
        endcase
    end

    // Synchroniser, stability counter and capture-window FSM.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= '1;
            r_s     <= '1;
            r_p     <= '1;
            r_cnt   <= 8'd0;
            r_state <= ST_WAIT;
        end else begin
            r_sync1 <= {bus.seg_n, bus.dig_n};
            r_s     <= r_sync1;
            r_p     <= r_s;
            if (!w_stable)
                r_cnt <= 8'd0;
            else if (r_cnt != 8'hFF)
                r_cnt <= r_cnt + 8'd1;
            case (r_state)
                ST_WAIT: if (w_window)  r_state <= ST_HOLD;
                ST_HOLD: if (!w_stable) r_state <= ST_WAIT;
                default: r_state <= ST_WAIT;
            endcase
        end
    end

    // Slot staging and frame publish; a capture during publish starts the next frame.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stg_val <= '0;
            r_stg_dp  <= '0;
            r_stg_err <= '0;
            r_seen    <= '0;
            r_value   <= '0;
            r_dp      <= '0;
            r_err     <= '0;
            r_fv      <= 1'b0;
            r_fe      <= 1'b0;
        end else begin
            r_fv <= 1'b0;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (w_cap_mask[i]) begin
                    r_stg_val[4*i +: 4] <= w_nib;
                    r_stg_dp[i]         <= w_dp_lit;
                    r_stg_err[i]        <= w_bad;
                end
            end
            if (w_full) begin
                r_value <= r_stg_val;
                r_dp    <= r_stg_dp;
                r_err   <= r_stg_err;
                r_fe    <= |r_stg_err;
                r_fv    <= 1'b1;
                r_seen  <= w_cap_mask;
            end else begin
                r_seen  <= r_seen | w_cap_mask;
            end
        end
    end

    assign bus.value       = r_value;
    assign bus.dp          = r_dp;
    assign bus.err         = r_err;
    assign bus.frame_valid = r_fv;
    assign bus.frame_err   = r_fe;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Randomised and directed bench for seven_seg_capture; expected frames come from an
// event-level model of hold windows, glyph lookup and slot bookkeeping.
module tb_seven_seg_capture;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned S      = 4;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    seven_seg_capture_if #(.DIGITS(DIGITS)) bus ();
    seven_seg_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Frame record: {frame_err, err, dp, value}
    logic [24:0] exp_q [$];
    logic [24:0] got_q [$];

    logic [3:0]  m_val [4];
    logic [3:0]  m_dp, m_err, m_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (bus.frame_valid === 1'b1)
            got_q.push_back({bus.frame_err, bus.err, bus.dp, bus.value});

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_val[i] = 4'h0;
        m_dp = '0; m_err = '0; m_seen = '0;
    endtask

    // One stable window long enough: decode glyph into the enabled slot, publish when all seen.
    task automatic model_capture(input logic [7:0] seg, input logic [3:0] dig);
        logic [3:0] act;
        int slot;
        logic found;
        act = ~dig;
        if ($countones(act) != 1) return;
        slot = 0;
        for (int i = 0; i < 4; i++) if (act[i]) slot = i;
        found = 1'b0;
        m_val[slot] = 4'h0;
        for (int n = 0; n < 16; n++)
            if (GLYPH[n] == ~seg[6:0]) begin m_val[slot] = 4'(n); found = 1'b1; end
        m_err[slot]  = ~found;
        m_dp[slot]   = ~seg[7];
        m_seen[slot] = 1'b1;
        if (m_seen == 4'hF) begin
            exp_q.push_back({|m_err, m_err, m_dp, m_val[3], m_val[2], m_val[1], m_val[0]});
            m_seen = '0;
        end
    endtask

    // Drive a pin pattern for h clock edges; windows of at least S+1 edges produce a capture.
    task automatic hold(input logic [7:0] seg, input logic [3:0] dig, input int h);
        @(negedge clk);
        bus.seg_n = seg;
        bus.dig_n = dig;
        repeat (h) @(posedge clk);
        if (h >= int'(S) + 1) model_capture(seg, dig);
    endtask

    task automatic dark(input int h);
        hold(8'hFF, 4'hF, h);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        resetn = 1'b0;
        model_clear();
        @(negedge clk);
        check("rst_value", 32'(bus.value), 32'h0);
        check("rst_fv", 32'(bus.frame_valid), 32'h0);
        resetn = 1'b1;
    endtask

    task automatic cmp_frames(input string tag);
        int n;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check({tag, "_frame"}, 32'(got_q[i]), 32'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [7:0] glyph_n(input int n, input logic dpl);
        return ~{dpl, GLYPH[n]};
    endfunction

    initial begin
        logic [7:0] seg;
        logic [3:0] dig;
        bus.seg_n = 8'hFF;
        bus.dig_n = 4'hF;
        resetn    = 1'b0;
        model_clear();

        // Reset held while pins toggle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.seg_n = 8'($urandom);
            bus.dig_n = 4'($urandom);
            check("reset_hold_out", {bus.frame_err, bus.frame_valid, bus.err, bus.dp, bus.value},
                  32'h0);
        end
        @(negedge clk);
        bus.seg_n = 8'hFF;
        bus.dig_n = 4'hF;
        resetn    = 1'b1;
        dark(6);
        check("reset_release_out", {bus.frame_err, bus.frame_valid, bus.err, bus.dp, bus.value},
              32'h0);
        cmp_frames("reset");

        // Basic frame, with pulse latency after the final capture
        hold(8'hF9, 4'hE, 8);
        hold(8'hA4, 4'hD, 8);
        hold(8'h88, 4'hB, 8);
        hold(8'h8E, 4'h7, 8);
        @(negedge clk);
        check("fv_latency", 32'(bus.frame_valid), 32'h1);
        @(negedge clk);
        check("fv_single", 32'(bus.frame_valid), 32'h0);
        check("frame_value", 32'(bus.value), 32'hFA21);
        check("frame_dp_err", {bus.frame_err, bus.err, bus.dp}, 32'h0);
        dark(6);
        cmp_frames("frame");

        // Short glitch on slot 0 must not count toward the frame
        hold(8'hA4, 4'hD, 8);
        hold(8'h88, 4'hB, 8);
        hold(8'hC0, 4'hE, 3);
        dark(2);
        hold(8'h8E, 4'h7, 8);
        dark(6);
        check("glitch_no_frame", 32'(got_q.size()), 32'h0);
        hold(8'hF9, 4'hE, 8);
        dark(6);
        cmp_frames("glitch");

        // Exact window boundary: S edges is too short, S+1 captures
        hold(8'hF9, 4'hE, int'(S));
        dark(2);
        hold(8'hA4, 4'hD, int'(S) + 1);
        hold(8'h88, 4'hB, int'(S) + 1);
        hold(8'h8E, 4'h7, int'(S) + 1);
        dark(6);
        check("boundary_no_frame", 32'(got_q.size()), 32'h0);
        hold(8'hF9, 4'hE, int'(S) + 1);
        dark(6);
        cmp_frames("boundary");

        // Illegal glyph in slot 2
        hold(8'hF9, 4'hE, 8);
        hold(8'hA4, 4'hD, 8);
        hold(8'hB6, 4'hB, 8);
        hold(8'h8E, 4'h7, 8);
        dark(6);
        check("illegal_value", 32'(bus.value), 32'hF021);
        check("illegal_err", {bus.frame_err, bus.err}, 32'h14);
        cmp_frames("illegal");

        // Decimal point on slot 0
        hold(8'h40, 4'hE, 8);
        hold(8'hA4, 4'hD, 8);
        hold(8'h88, 4'hB, 8);
        hold(8'h8E, 4'h7, 8);
        dark(6);
        check("dp_bits", {bus.err, bus.dp}, 32'h01);
        check("dp_value", 32'(bus.value), 32'hFA20);
        cmp_frames("dp");

        // Reset mid-frame discards earlier captures
        hold(8'hF9, 4'hE, 8);
        hold(8'hA4, 4'hD, 8);
        dark(6);
        pulse_reset();
        hold(8'h88, 4'hB, 8);
        hold(8'h8E, 4'h7, 8);
        dark(6);
        check("midreset_no_frame", 32'(got_q.size()), 32'h0);
        hold(glyph_n(7, 1'b0), 4'hE, 8);
        hold(glyph_n(3, 1'b1), 4'hD, 8);
        dark(6);
        cmp_frames("midreset");

        // Random pin traffic
        for (int k = 0; k < 300; k++) begin
            dark(int'($urandom_range(1, 3)));
            if ($urandom_range(0, 9) < 8) dig = ~(4'b0001 << $urandom_range(0, 3));
            else                           dig = 4'($urandom);
            if ($urandom_range(0, 19) < 17) seg = glyph_n(int'($urandom_range(0, 15)), 1'($urandom));
            else                            seg = 8'($urandom);
            if (dig == 4'hF && seg == 8'hFF) seg = 8'hFE;
            hold(seg, dig, int'($urandom_range(2, 9)));
        end
        dark(8);
        cmp_frames("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
